// File: rtl/rom_table_writer.sv
// Writable 2**ADDR_W x DATA_W lookup table. Words are streamed in through a
// valid/ready load sequence, and a combinational read port mirrors the ROM it replaces.
module rom_table_writer #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              busy,
   output logic              done,
   input  logic [ADDR_W-1:0] a,
   output logic [DATA_W-1:0] b,
   output logic [1:0]        state_dbg
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      FULL = 2'd2
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] addr_next;
   logic              done_next;
   logic              wr_en;

   logic [DATA_W-1:0] mem [0:DEPTH-1];

   // Handshake: a word transfers on a rising edge where wr_valid and wr_ready are
   // both high; wr_ready depends only on registered state, never on wr_valid.
   assign wr_ready  = (state == LOAD);
   assign busy      = (state == LOAD);
   assign state_dbg = state;

   always_comb begin
      state_next = state;
      addr_next  = wr_addr;
      done_next  = done;
      wr_en      = 1'b0;
      case (state)
         IDLE, FULL: begin
            if (start) begin
               state_next = LOAD;
               addr_next  = '0;
               done_next  = 1'b0;
            end
         end
         LOAD: begin
            if (wr_valid) begin
               wr_en = 1'b1;
               if (wr_addr == LAST_ADDR) begin
                  addr_next  = '0;
                  done_next  = 1'b1;
                  state_next = FULL;
               end else begin
                  addr_next = wr_addr + 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
            addr_next  = '0;
            done_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         wr_addr <= '0;
         done    <= 1'b0;
      end else begin
         state   <= state_next;
         wr_addr <= addr_next;
         done    <= done_next;
      end
   end

   // Table contents survive reset; an aborted load keeps whatever it already wrote.
   always_ff @(posedge clk) begin
      if (wr_en && !reset) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign b = mem[a];

endmodule

// File: doc/rom_table_writer.md
Name: rom_table_writer

Overview:
- Writable counterpart to the 8-bit-address / 3-bit-data lookup ROM.
- Accepts a stream of 3-bit words over a valid/ready handshake and writes them into an internal 256x3 table at an auto-incrementing address.
- Exposes a combinational read port (a -> b) with the same shape as the ROM, so it can replace the ROM behind the 8-bit address counter.
- Lets benches and boot logic load table contents at run time instead of fixing them at synthesis.

Parameters:
- ADDR_W, 8, address width; table depth is 2**ADDR_W.
- DATA_W, 3, word width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load sequence at address 0.
- wr_valid  input  1  write word present on wr_data.
- wr_data  input  DATA_W  word to write.
- wr_ready  output  1  block accepts a word this cycle.
- wr_addr  output  ADDR_W  address the next accepted word is written to.
- busy  output  1  high while in LOAD.
- done  output  1  high once all 2**ADDR_W entries are written; held until next start or reset.
- a  input  ADDR_W  read address.
- b  output  DATA_W  read data, combinational from a.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. The clock port is clk and the reset port is reset.
- Reset (sampled on the rising edge of clk with reset=1) sets:
  - state=IDLE, wr_addr=0, done=0, busy=0, wr_ready=0.
  - Table contents are NOT cleared; entries keep their last written values.
- FSM states: IDLE, LOAD, FULL.
- IDLE:
  - wr_ready=0; wr_valid is ignored.
  - start=1 -> LOAD next cycle, wr_addr<=0, done<=0.
- LOAD:
  - busy=1, wr_ready=1.
  - Transfer occurs when wr_valid=1 and wr_ready=1 at the rising edge: mem[wr_addr]<=wr_data.
  - On a transfer with wr_addr < 2**ADDR_W-1: wr_addr<=wr_addr+1.
  - On a transfer with wr_addr == 2**ADDR_W-1: wr_addr wraps to 0, done<=1, next state FULL.
  - wr_valid=0 stalls the sequence; wr_addr and the table are unchanged. Stalls may be any length.
  - start=1 in LOAD is ignored; there is no restart mid-load.
- FULL:
  - wr_ready=0, busy=0, done=1; wr_valid is ignored.
  - start=1 -> LOAD, wr_addr<=0, done<=0. Old contents stay readable until they are overwritten.
- Registered outputs: wr_ready and busy are decoded from the registered state, so there is no combinational path from wr_valid or start.
- Read port:
  - b = mem[a], purely combinational, zero latency.
  - It is independent of state and readable in every state, including during LOAD.
- Read and write to the same address in one cycle: b shows the old value before the edge and the new value after it.
- Reset mid-load: the sequence aborts to IDLE with wr_addr=0 and done=0. Entries already written keep their values; unwritten entries keep their prior values.
- Reset and start in the same cycle: reset wins.
- Write acceptance and timing:
  - Exactly one word is written per accepted handshake; no word is written while wr_ready=0.
  - Throughput is 1 word/cycle.
  - A full load takes 256 accepted cycles; done rises on the edge of the 256th transfer.
- Reading an entry never written since power-up returns X. Benches must only check written entries.

Test Plan:
- Basic load and readback:
  - Stimulus: reset 8 cycles, pulse start, drive wr_valid=1 continuously with wr_data=wr_addr[2:0]. Then sweep a=0..255 with the 8-bit enabled counter.
  - Required response: wr_ready=1 from the cycle after start; done=1 exactly 256 cycles after the first transfer; wr_addr=0 afterwards; b==a[2:0] for all 256 addresses.
- Stalls:
  - Stimulus: during load, toggle wr_valid with a pseudo-random pattern (about 50%).
  - Required response: wr_addr advances only on cycles with wr_valid=1; final contents still give b==a[2:0]; done asserts only after 256 transfers.
- Ignored inputs:
  - Stimulus: wr_valid=1, wr_data=3'b111 in IDLE, then start again mid-load at wr_addr=40.
  - Required response: nothing is written in IDLE; the second start causes no reset of wr_addr, and wr_addr=41 after the next transfer.
- Reset mid-load:
  - Stimulus: load data 3'b101 up to wr_addr=100, then assert reset for 1 cycle.
  - Required response: the next cycle shows state IDLE, wr_addr=0, done=0, busy=0; a=0..99 read 3'b101.
- Reload after full:
  - Stimulus: after a complete load, pulse start and load ~wr_addr[2:0].
  - Required response: done drops the cycle after start; b==~a[2:0] at addresses already rewritten and still the old values at addresses not yet rewritten; done=1 again at the end.
- Same-address read/write:
  - Stimulus: a held at wr_addr=7 while writing 3'b010 over an old value of 3'b111.
  - Required response: b=3'b111 before the edge and 3'b010 after it.
